// File: rtl/uart_tx_frame.sv
// Serial UART frame transmitter: start bit, WIDTH data bits LSB first, optional
// even/odd parity bit, one stop bit. One line bit per clock edge.
module uart_tx_frame #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] P_DATA,
   input  logic             Data_Valid,
   input  logic             PAR_EN,
   input  logic             PAR_TYP,
   output logic             TX_OUT,
   output logic             Busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic [WIDTH-1:0] data_q;
   logic             par_en_q;
   logic             par_typ_q;

   assign cnt_nxt = cnt + CNT_W'(1);

   function automatic logic parity_bit(input logic [WIDTH-1:0] d, input logic odd);
      return (^d) ^ odd;
   endfunction

   // Outputs are loaded with the value of the state being entered, so the line
   // and Busy always come straight from flops.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         data_q    <= '0;
         par_en_q  <= 1'b0;
         par_typ_q <= 1'b0;
         TX_OUT    <= 1'b1;
         Busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (Data_Valid) begin
                  data_q    <= P_DATA;
                  par_en_q  <= PAR_EN;
                  par_typ_q <= PAR_TYP;
                  state     <= START;
                  TX_OUT    <= 1'b0;
                  Busy      <= 1'b1;
               end else begin
                  TX_OUT <= 1'b1;
                  Busy   <= 1'b0;
               end
            end
            START: begin
               state  <= DATA;
               cnt    <= '0;
               TX_OUT <= data_q[0];
               Busy   <= 1'b1;
            end
            DATA: begin
               Busy <= 1'b1;
               if (cnt == CNT_LAST) begin
                  if (par_en_q) begin
                     state  <= PARITY;
                     TX_OUT <= parity_bit(data_q, par_typ_q);
                  end else begin
                     state  <= STOP;
                     TX_OUT <= 1'b1;
                  end
               end else begin
                  cnt    <= cnt_nxt;
                  TX_OUT <= data_q[cnt_nxt];
               end
            end
            PARITY: begin
               state  <= STOP;
               TX_OUT <= 1'b1;
               Busy   <= 1'b1;
            end
            STOP: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
            default: begin
               state  <= IDLE;
               TX_OUT <= 1'b1;
               Busy   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of hand-computed frames plus
// sequences for mid-frame requests, back-to-back frames and async reset.
module tb_uart_tx_frame;

   logic       clk;
   logic       rst;
   logic [7:0] P_DATA;
   logic       Data_Valid;
   logic       PAR_EN;
   logic       PAR_TYP;
   logic       TX_OUT;
   logic       Busy;

   int n_checks;
   int n_fail;

   uart_tx_frame #(.WIDTH(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .P_DATA     (P_DATA),
      .Data_Valid (Data_Valid),
      .PAR_EN     (PAR_EN),
      .PAR_TYP    (PAR_TYP),
      .TX_OUT     (TX_OUT),
      .Busy       (Busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // frame[i] is the line value i cycles after acceptance: start, data LSB
   // first, optional parity, stop, then the idle cycle at index len.
   typedef struct {
      string      name;
      logic [7:0] data;
      logic       par_en;
      logic       par_typ;
      int         len;
      logic [0:11] frame;
   } vec_t;

   vec_t vecs [11];

   task automatic check(input string name, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
      end
   endtask

   task automatic launch(input int idx, input bit pulse);
      @(negedge clk);
      P_DATA     = vecs[idx].data;
      PAR_EN     = vecs[idx].par_en;
      PAR_TYP    = vecs[idx].par_typ;
      Data_Valid = 1'b1;
      @(posedge clk);
      #1;
      if (pulse) Data_Valid = 1'b0;
   endtask

   // Samples every cycle of the frame plus the trailing idle cycle. With
   // disturb_at >= 0 a conflicting request is pulsed mid-frame.
   task automatic check_frame(input int idx, input int disturb_at);
      for (int i = 0; i <= vecs[idx].len; i++) begin
         @(negedge clk);
         check($sformatf("%s tx[%0d]", vecs[idx].name, i), TX_OUT, vecs[idx].frame[i]);
         check($sformatf("%s busy[%0d]", vecs[idx].name, i), Busy, i < vecs[idx].len);
         if (i == disturb_at) begin
            Data_Valid = 1'b1;
            P_DATA     = 8'hFF;
            PAR_EN     = 1'b1;
            PAR_TYP    = 1'b1;
         end else if (disturb_at >= 0 && i == disturb_at + 1) begin
            Data_Valid = 1'b0;
            P_DATA     = 8'h00;
         end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_checks = 0;
      n_fail   = 0;
      vecs[0]  = '{"a5_nopar", 8'hA5, 1'b0, 1'b0, 10, 12'b0_10100101_1_1_1};
      vecs[1]  = '{"a5_even",  8'hA5, 1'b1, 1'b0, 11, 12'b0_10100101_0_1_1};
      vecs[2]  = '{"a5_odd",   8'hA5, 1'b1, 1'b1, 11, 12'b0_10100101_1_1_1};
      vecs[3]  = '{"00_odd",   8'h00, 1'b1, 1'b1, 11, 12'b0_00000000_1_1_1};
      vecs[4]  = '{"ff_even",  8'hFF, 1'b1, 1'b0, 11, 12'b0_11111111_0_1_1};
      vecs[5]  = '{"01_even",  8'h01, 1'b1, 1'b0, 11, 12'b0_10000000_1_1_1};
      vecs[6]  = '{"01_odd",   8'h01, 1'b1, 1'b1, 11, 12'b0_10000000_0_1_1};
      vecs[7]  = '{"3c_nopar", 8'h3C, 1'b0, 1'b0, 10, 12'b0_00111100_1_1_1};
      vecs[8]  = '{"01_nopar", 8'h01, 1'b0, 1'b0, 10, 12'b0_10000000_1_1_1};
      vecs[9]  = '{"80_nopar", 8'h80, 1'b0, 1'b0, 10, 12'b0_00000001_1_1_1};
      vecs[10] = '{"55_nopar", 8'h55, 1'b0, 1'b0, 10, 12'b0_10101010_1_1_1};

      rst        = 1'b1;
      P_DATA     = 8'h00;
      Data_Valid = 1'b0;
      PAR_EN     = 1'b0;
      PAR_TYP    = 1'b0;

      repeat (2) begin
         @(negedge clk);
         check("reset tx", TX_OUT, 1'b1);
         check("reset busy", Busy, 1'b0);
      end
      rst = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         check($sformatf("idle tx[%0d]", i), TX_OUT, 1'b1);
         check($sformatf("idle busy[%0d]", i), Busy, 1'b0);
      end

      for (int v = 0; v <= 6; v++) begin
         launch(v, 1'b1);
         check_frame(v, -1);
      end

      // Conflicting request and input changes during an active frame.
      launch(7, 1'b1);
      check_frame(7, 3);
      repeat (3) begin
         @(negedge clk);
         check("post_ignore tx", TX_OUT, 1'b1);
         check("post_ignore busy", Busy, 1'b0);
      end

      // Data_Valid held: second frame starts right after one idle cycle.
      launch(8, 1'b0);
      P_DATA  = vecs[9].data;
      PAR_EN  = vecs[9].par_en;
      PAR_TYP = vecs[9].par_typ;
      check_frame(8, -1);
      @(posedge clk);
      #1;
      Data_Valid = 1'b0;
      check_frame(9, -1);

      // Async reset during data bit 3, then restart on release.
      launch(0, 1'b1);
      for (int i = 0; i <= 4; i++) begin
         @(negedge clk);
         check($sformatf("pre_rst tx[%0d]", i), TX_OUT, vecs[0].frame[i]);
      end
      #2;
      rst = 1'b1;
      #1;
      check("async_rst tx", TX_OUT, 1'b1);
      check("async_rst busy", Busy, 1'b0);
      @(negedge clk);
      check("in_rst tx", TX_OUT, 1'b1);
      check("in_rst busy", Busy, 1'b0);
      P_DATA     = vecs[10].data;
      PAR_EN     = vecs[10].par_en;
      PAR_TYP    = vecs[10].par_typ;
      Data_Valid = 1'b1;
      rst        = 1'b0;
      @(posedge clk);
      #1;
      Data_Valid = 1'b0;
      check_frame(10, -1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
